// File: rtl/shift_deser_pkg.sv
// shift_deser_pkg: shared FSM state encoding and counter sizing for the MSB-first deserializer.
package shift_deser_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        PARITY
    } state_e;

    // The counter must reach WIDTH, which is where a word waits for its parity bit.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/shift_deser_hold.sv
// shift_deser_hold: one-entry valid/ready holding register; drops a word arriving while full and pulses overrun.
module shift_deser_hold #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load_i,
    input  logic [DW-1:0] data_i,
    input  logic          ready_i,
    output logic          valid_o,
    output logic [DW-1:0] data_o,
    output logic          overrun_o
);

    logic          valid_q, valid_d;
    logic [DW-1:0] data_q, data_d;
    logic          overrun_q, overrun_d;
    logic          blocked;

    // Full and not being drained this cycle: a new word has nowhere to go.
    assign blocked   = valid_q && !ready_i;
    assign overrun_d = load_i && blocked;
    assign valid_d   = (load_i && !blocked) ? 1'b1 : (valid_q && !ready_i);
    assign data_d    = (load_i && !blocked) ? data_i : data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q   <= 1'b0;
            data_q    <= '0;
            overrun_q <= 1'b0;
        end else begin
            valid_q   <= valid_d;
            data_q    <= data_d;
            overrun_q <= overrun_d;
        end
    end

    assign valid_o   = valid_q;
    assign data_o    = data_q;
    assign overrun_o = overrun_q;

endmodule

// File: rtl/shift_deserializer_msb.sv
// shift_deserializer_msb: MSB-first serial-to-parallel receiver with a one-entry valid/ready output.
// Define SHIFT_DESER_PARITY_EN to expect a trailing even-parity bit per word and expose parity_err.
module shift_deserializer_msb
    import shift_deser_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             sync,
    input  logic             serial_in,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             busy,
    output logic             overrun
`ifdef SHIFT_DESER_PARITY_EN
    ,
    output logic             parity_err
`endif
);

    localparam int CW = cnt_width(WIDTH);
`ifdef SHIFT_DESER_PARITY_EN
    localparam int HW = WIDTH + 1;
`else
    localparam int HW = WIDTH;
`endif

    state_e           state_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic             last_bit, done;
    logic [HW-1:0]    word_d, hold_q;

    assign shreg_d  = {shreg_q[WIDTH-2:0], serial_in};
    assign last_bit = cnt_q == CW'(WIDTH - 1);
    assign busy     = cnt_q != '0;

`ifdef SHIFT_DESER_PARITY_EN
    assign done       = en && !sync && state_q == PARITY;
    assign word_d     = {^{shreg_q, serial_in}, shreg_q};
    assign parity_err = hold_q[WIDTH];
`else
    assign done   = en && !sync && last_bit;
    assign word_d = shreg_d;
`endif
    assign out_data = hold_q[WIDTH-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shreg_q <= '0;
        end else if (sync) begin
            // A strobe coinciding with sync is the first bit of the new frame.
            state_q <= en ? SHIFT : IDLE;
            cnt_q   <= en ? CW'(1) : '0;
            shreg_q <= en ? WIDTH'(serial_in) : '0;
        end else if (en) begin
            case (state_q)
                PARITY: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                    shreg_q <= '0;
                end
                default: begin
                    if (!last_bit) begin
                        state_q <= SHIFT;
                        cnt_q   <= cnt_q + CW'(1);
                        shreg_q <= shreg_d;
                    end else begin
`ifdef SHIFT_DESER_PARITY_EN
                        state_q <= PARITY;
                        cnt_q   <= CW'(WIDTH);
                        shreg_q <= shreg_d;
`else
                        state_q <= IDLE;
                        cnt_q   <= '0;
                        shreg_q <= '0;
`endif
                    end
                end
            endcase
        end
    end

    shift_deser_hold #(
        .DW(HW)
    ) u_hold (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_i   (done),
        .data_i   (word_d),
        .ready_i  (out_ready),
        .valid_o  (out_valid),
        .data_o   (hold_q),
        .overrun_o(overrun)
    );

endmodule

// File: tb/tb_shift_deserializer_msb.sv
// tb_shift_deserializer_msb: table vectors plus directed handshake, overrun, sync and reset sequences.
module tb_shift_deserializer_msb;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       sync = 1'b0;
    logic       serial_in = 1'b0;
    logic       out_ready = 1'b0;
    logic       out_valid;
    logic [7:0] out_data;
    logic       busy;
    logic       overrun;
`ifdef SHIFT_DESER_PARITY_EN
    logic       parity_err;
`endif

    int total = 0;
    int bad = 0;
    logic [8:0] sb[$];
    logic [8:0] sb_e;

    typedef struct {
        logic [7:0] seq;
        int         gap;
        logic [7:0] exp;
    } vec_t;
    vec_t vecs[7];

    always #5 clk = ~clk;

    shift_deserializer_msb #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .sync      (sync),
        .serial_in (serial_in),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .busy      (busy),
        .overrun   (overrun)
`ifdef SHIFT_DESER_PARITY_EN
        ,
        .parity_err(parity_err)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bit_(input logic b);
        en = 1'b1;
        serial_in = b;
        @(posedge clk);
        #1;
        en = 1'b0;
        serial_in = 1'b0;
    endtask

    task automatic send_head(input logic [7:0] w, input int gap);
        for (int i = 7; i >= 1; i--) begin
            idle($urandom_range(gap, 0));
            bit_(w[i]);
        end
    endtask

    task automatic send_tail(input logic [7:0] w);
        bit_(w[0]);
`ifdef SHIFT_DESER_PARITY_EN
        bit_(^w);
`endif
    endtask

    task automatic send(input logic [7:0] w, input int gap);
        send_head(w, gap);
        idle($urandom_range(gap, 0));
        send_tail(w);
    endtask

    // Every accepted word must match the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_unexpected: got %0h expected no word", out_data);
            end else begin
                sb_e = sb.pop_front();
                chk("sb_data", {24'd0, out_data}, {24'd0, sb_e[7:0]});
`ifdef SHIFT_DESER_PARITY_EN
                chk("sb_perr", {31'd0, parity_err}, {31'd0, sb_e[8]});
`endif
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{8'h01, 0, 8'h80};
        vecs[1] = '{8'h80, 1, 8'h01};
        vecs[2] = '{8'h0F, 0, 8'hF0};
        vecs[3] = '{8'hFF, 2, 8'hFF};
        vecs[4] = '{8'h00, 0, 8'h00};
        vecs[5] = '{8'h35, 3, 8'hAC};
        vecs[6] = '{8'h12, 1, 8'h48};

        #3;
        chk("rst_valid", {31'd0, out_valid}, 0);
        chk("rst_data", {24'd0, out_data}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_overrun", {31'd0, overrun}, 0);
        idle(2);
        rst_n = 1'b1;
        idle(1);

        // A5, consecutive strobes, downstream always ready
        out_ready = 1'b1;
        sb.push_back({1'b0, 8'hA5});
        send(8'hA5, 0);
        chk("a5_valid", {31'd0, out_valid}, 1);
        chk("a5_data", {24'd0, out_data}, 32'hA5);
        chk("a5_busy", {31'd0, busy}, 0);
        idle(1);
        chk("a5_drained", {31'd0, out_valid}, 0);

        // 3C held, FF dropped with a one-cycle overrun pulse
        out_ready = 1'b0;
        sb.push_back({1'b0, 8'h3C});
        send(8'h3C, 0);
        send(8'hFF, 0);
        chk("ovr_pulse", {31'd0, overrun}, 1);
        chk("ovr_keep", {24'd0, out_data}, 32'h3C);
        chk("ovr_valid", {31'd0, out_valid}, 1);
        chk("ovr_busy", {31'd0, busy}, 0);
        idle(1);
        chk("ovr_one_cycle", {31'd0, overrun}, 0);
        chk("ovr_keep2", {24'd0, out_data}, 32'h3C);
        out_ready = 1'b1;
        idle(1);
        chk("ovr_drained", {31'd0, out_valid}, 0);
        out_ready = 1'b0;

        // completion coinciding with accept replaces the word, no overrun
        sb.push_back({1'b0, 8'h11});
        send(8'h11, 0);
        sb.push_back({1'b0, 8'h22});
        send_head(8'h22, 0);
        out_ready = 1'b1;
        send_tail(8'h22);
        chk("swap_valid", {31'd0, out_valid}, 1);
        chk("swap_data", {24'd0, out_data}, 32'h22);
        chk("swap_overrun", {31'd0, overrun}, 0);
        idle(2);

        // sync with en restarts the frame with this bit as the MSB
        sb.push_back({1'b0, 8'h81});
        bit_(1'b1);
        bit_(1'b0);
        bit_(1'b1);
        sync = 1'b1;
        bit_(1'b1);
        sync = 1'b0;
        chk("sync_busy", {31'd0, busy}, 1);
        repeat (6) bit_(1'b0);
        send_tail(8'h81);
        chk("sync_data", {24'd0, out_data}, 32'h81);
        chk("sync_idle", {31'd0, busy}, 0);
        idle(2);

        // asynchronous reset mid-frame with a word held
        out_ready = 1'b0;
        send(8'h77, 0);
        bit_(1'b1);
        bit_(1'b0);
        bit_(1'b1);
        bit_(1'b1);
        bit_(1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", {31'd0, out_valid}, 0);
        chk("arst_data", {24'd0, out_data}, 0);
        chk("arst_busy", {31'd0, busy}, 0);
        chk("arst_overrun", {31'd0, overrun}, 0);
        idle(2);
        rst_n = 1'b1;
        out_ready = 1'b1;
        sb.push_back({1'b0, 8'h5A});
        send(8'h5A, 3);
        chk("gap_data", {24'd0, out_data}, 32'h5A);
        idle(2);

        // table: seq[i] is the i-th bit on the wire
        foreach (vecs[k]) begin
            sb.push_back({1'b0, vecs[k].exp});
            for (int i = 0; i < 8; i++) begin
                idle($urandom_range(vecs[k].gap, 0));
                bit_(vecs[k].seq[i]);
            end
`ifdef SHIFT_DESER_PARITY_EN
            bit_(^vecs[k].seq);
`endif
            chk("vec_valid", {31'd0, out_valid}, 1);
            idle(1);
        end

`ifdef SHIFT_DESER_PARITY_EN
        for (int p = 0; p < 2; p++) begin
            sb.push_back({p[0], 8'hA5});
            for (int i = 7; i >= 0; i--) bit_(8'hA5 >> i);
            chk("par_wait_valid", {31'd0, out_valid}, 0);
            chk("par_wait_busy", {31'd0, busy}, 1);
            bit_(p[0]);
            chk("par_valid", {31'd0, out_valid}, 1);
            chk("par_err", {31'd0, parity_err}, {31'd0, p[0]});
            idle(2);
        end
`endif

        idle(2);
        chk("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
